piu_pchidx_iter: RTL
====================

Name: piu_pchidx_iter

Overview:
- Consumer of the patch bitmasks (pchlist / esmon / merged) that the PIU next-source logic produces.
- Loads one NUM_PCH-wide mask and walks it lowest-index-first, emitting one patch index per accepted handshake, with its row/column.
- Returns the not-yet-visited mask as next_pchidxsrc so the source selector can reload it.
- Sits between the PIU mask registers and the per-patch downstream units.

Parameters:
NUM_PCH, 20, number of patches (mask width)
NUM_PCHCOL, 5, patches per row; row = idx / NUM_PCHCOL, col = idx % NUM_PCHCOL
PCHIDX_W, $clog2(NUM_PCH), width of an emitted patch index

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
load_valid  input  1  mask offered
load_ready  output  1  block can accept a mask (state IDLE)
load_src  input  2  PCHIDXSRC_* code identifying the mask source
load_mask  input  NUM_PCH  patch bitmask to iterate
flush  input  1  abort the current iteration
out_valid  output  1  out_pchidx is valid
out_ready  input  1  downstream accepts the index
out_pchidx  output  PCHIDX_W  lowest set bit of the current mask
out_row  output  PCHIDX_W  out_pchidx / NUM_PCHCOL
out_col  output  PCHIDX_W  out_pchidx % NUM_PCHCOL
out_src  output  2  load_src captured at load
out_last  output  1  current index is the final set bit
next_pchidxsrc  output  NUM_PCH  current mask with the out_pchidx bit cleared
sel_pchidxsrc  output  2  equals out_src while busy, else 0
done  output  1  one-cycle pulse when iteration ends
busy  output  1  state != IDLE

Behaviour:
- Interface rule: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, mask 0, src 0, all outputs 0 except load_ready = 1. next_pchidxsrc = 0.
- States: IDLE, ITER, DONE.
- IDLE:
  - load_ready = 1.
  - On load_valid: capture load_mask and load_src.
  - Go to ITER if the mask is non-zero, otherwise go to DONE.
- ITER:
  - out_valid = 1. All out_* and next_pchidxsrc derive combinationally from the registered mask. out_last = (popcount of mask == 1).
  - On out_ready: clear the lowest set bit. One index per cycle, full throughput.
  - After the handshake that has out_last set, go to DONE.
  - Without out_ready, hold all outputs stable.
- DONE:
  - done = 1 for exactly one cycle.
  - Mask cleared, then return to IDLE.
  - load_ready = 0 in DONE; the earliest next load is the following cycle.
- Latency:
  - First index is valid 1 cycle after the load handshake.
  - A k-bit mask with out_ready held high gives done k+1 cycles after load.
  - An empty mask gives done 1 cycle after load, with no out_valid.
- flush:
  - In ITER: next cycle is DONE (done still pulses), remaining bits are discarded, and a coincident out handshake is ignored.
  - In IDLE: flush has priority over load.
  - In DONE: no effect.
- rst at any point, including mid-iteration: outputs return to reset values in the next cycle, and no done pulse is produced.
- Bits above NUM_PCH-1 do not exist. Indices emitted are strictly increasing, and every bit is emitted exactly once.
- out_row / out_col use constant-divisor arithmetic, truncated to PCHIDX_W.

Decomposition:
- Shared include define.v holds NUM_PCH, NUM_PCHCOL, and the PCHIDXSRC_PCHLIST / ESMON / MERGED codes.
- Add a state encoding to define.v: PIU_ITER_IDLE = 0, ITER = 1, DONE = 2.
- One sub-module, piu_lsb_enc: combinational lowest-set-bit encoder. Outputs are index, one-hot, and a single-bit flag.
- out_last comes from the parent as (mask & (mask-1)) == 0.

Test Plan:
- Basic walk: load mask 0x00015 (bits 0, 2, 4) from ESMON with out_ready = 1 → indices 0, 2, 4 on consecutive cycles, out_last only on 4, done on the 4th cycle after load, out_src = ESMON. Check next_pchidxsrc = 0x14, 0x10, 0x0.
- Backpressure: load 0x80001, out_ready toggling 0, 1, 0, 0, 1 → index 0 held while not ready, then index 19 (row 3, col 4), out_last = 1, single done pulse.
- Empty mask: load 0x0 → done on the next cycle, out_valid never asserted, load_ready returns the cycle after done.
- Flush mid-walk: load 0xFFFFF, accept 3 indices, assert flush together with out_ready → no 4th handshake counted, done next cycle, then IDLE with next_pchidxsrc = 0.
- Reset mid-walk: load 0x00F00, assert rst after the first index → all outputs at reset values next cycle, no done; a new load of 0x00001 then works normally.
- Full-width mask: load 0xFFFFF with out_ready = 1 → 20 indices 0..19 with row/col (0,0)..(3,4), exactly one out_last and one done.

Source files
------------

// File: rtl/piu_pchidx_iter_pkg.sv
// Shared constants for the PIU patch-index iterator: mask geometry, source codes,
// iterator state encoding and the row/column helpers.
package piu_pchidx_iter_pkg;

  localparam int NUM_PCH    = 20;
  localparam int NUM_PCHCOL = 5;
  localparam int PCHIDX_W   = $clog2(NUM_PCH);

  localparam logic [31:0] PCHCOL_DIV = 32'(NUM_PCHCOL);

  // A zero source code means "no source selected".
  localparam logic [1:0] PCHIDXSRC_NONE    = 2'd0;
  localparam logic [1:0] PCHIDXSRC_PCHLIST = 2'd1;
  localparam logic [1:0] PCHIDXSRC_ESMON   = 2'd2;
  localparam logic [1:0] PCHIDXSRC_MERGED  = 2'd3;

  typedef enum logic [1:0] {
    PIU_ITER_IDLE = 2'd0,
    PIU_ITER_ITER = 2'd1,
    PIU_ITER_DONE = 2'd2
  } piu_iter_state_e;

  function automatic logic [PCHIDX_W-1:0] pch_row(input logic [PCHIDX_W-1:0] idx);
    return PCHIDX_W'(32'(idx) / PCHCOL_DIV);
  endfunction

  function automatic logic [PCHIDX_W-1:0] pch_col(input logic [PCHIDX_W-1:0] idx);
    return PCHIDX_W'(32'(idx) % PCHCOL_DIV);
  endfunction

endpackage

// File: rtl/piu_lsb_enc.sv
// Combinational lowest-set-bit encoder: position, one-hot isolate and any-bit flag.
module piu_lsb_enc #(
  parameter int W     = 20,
  parameter int IDX_W = 5
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [W-1:0]     onehot_o,
  output logic             found_o
);

  // Two's complement isolates the lowest set bit; its position is OR-encoded.
  always_comb begin
    onehot_o = vec_i & (~vec_i + {{(W-1){1'b0}}, 1'b1});
    idx_o    = {IDX_W{1'b0}};
    for (int i = 0; i < W; i++) begin
      idx_o = idx_o | ({IDX_W{onehot_o[i]}} & IDX_W'(i));
    end
    found_o  = |vec_i;
  end

endmodule

// File: rtl/piu_pchidx_iter.sv
// Walks one patch bitmask lowest-index-first, one index per accepted handshake,
// and hands the unvisited remainder back to the source selector.
module piu_pchidx_iter
  import piu_pchidx_iter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [1:0]          load_src,
  input  logic [NUM_PCH-1:0]  load_mask,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PCHIDX_W-1:0] out_pchidx,
  output logic [PCHIDX_W-1:0] out_row,
  output logic [PCHIDX_W-1:0] out_col,
  output logic [1:0]          out_src,
  output logic                out_last,
  output logic [NUM_PCH-1:0]  next_pchidxsrc,
  output logic [1:0]          sel_pchidxsrc,
  output logic                done,
  output logic                busy
);

  localparam logic [NUM_PCH-1:0] MASK_ZERO = {NUM_PCH{1'b0}};
  localparam logic [NUM_PCH-1:0] MASK_ONE  = {{(NUM_PCH-1){1'b0}}, 1'b1};

  piu_iter_state_e        state_q;
  logic [NUM_PCH-1:0]     mask_q;
  logic [1:0]             src_q;

  logic [PCHIDX_W-1:0]    lsb_idx_s;
  logic [NUM_PCH-1:0]     lsb_onehot_s;
  logic                   lsb_found_s;
  logic                   iter_s;
  logic                   single_s;

  piu_lsb_enc #(
    .W     (NUM_PCH),
    .IDX_W (PCHIDX_W)
  ) u_lsb_enc (
    .vec_i    (mask_q),
    .idx_o    (lsb_idx_s),
    .onehot_o (lsb_onehot_s),
    .found_o  (lsb_found_s)
  );

  assign iter_s   = (state_q == PIU_ITER_ITER);
  assign single_s = ((mask_q & (mask_q - MASK_ONE)) == MASK_ZERO);

  assign load_ready     = (state_q == PIU_ITER_IDLE);
  assign busy           = (state_q != PIU_ITER_IDLE);
  assign done           = (state_q == PIU_ITER_DONE);
  assign out_valid      = iter_s & lsb_found_s;
  assign out_last       = iter_s & lsb_found_s & single_s;
  assign out_pchidx     = lsb_idx_s;
  assign out_row        = pch_row(lsb_idx_s);
  assign out_col        = pch_col(lsb_idx_s);
  assign out_src        = src_q;
  assign sel_pchidxsrc  = busy ? src_q : PCHIDXSRC_NONE;
  assign next_pchidxsrc = mask_q & ~lsb_onehot_s;

  // Iterator FSM: load, consume one bit per handshake, one-cycle done, back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PIU_ITER_IDLE;
      mask_q  <= MASK_ZERO;
      src_q   <= PCHIDXSRC_NONE;
    end else begin
      case (state_q)
        PIU_ITER_IDLE: begin
          // flush wins over a coincident load
          if (load_valid && !flush) begin
            mask_q  <= load_mask;
            src_q   <= load_src;
            state_q <= (load_mask != MASK_ZERO) ? PIU_ITER_ITER : PIU_ITER_DONE;
          end
        end
        PIU_ITER_ITER: begin
          if (flush) begin
            mask_q  <= MASK_ZERO;
            state_q <= PIU_ITER_DONE;
          end else if (out_ready) begin
            mask_q <= mask_q & ~lsb_onehot_s;
            if (single_s) begin
              state_q <= PIU_ITER_DONE;
            end
          end
        end
        PIU_ITER_DONE: begin
          mask_q  <= MASK_ZERO;
          state_q <= PIU_ITER_IDLE;
        end
        default: begin
          mask_q  <= MASK_ZERO;
          state_q <= PIU_ITER_IDLE;
        end
      endcase
    end
  end

endmodule
